// File: rtl/fir_acc_out_if.sv
// -----------------------------------------------------------------------------
// fir_acc_out_if
//   Output sample stream of the FIR accumulator stage.
//   Handshake: a sample transfers on a rising clk edge where out_valid and
//   out_ready are both high. While out_valid is high the producer holds y_out
//   and sat_flag stable; out_valid never depends combinationally on out_ready.
//   Signals:
//     y_out     16-bit saturated sample, two's complement (producer -> consumer)
//     sat_flag  sample was clipped                        (producer -> consumer)
//     out_valid sample available                          (producer -> consumer)
//     out_ready consumer accepts the sample               (consumer -> producer)
// -----------------------------------------------------------------------------
interface fir_acc_out_if;
    logic [15:0] y_out;
    logic        sat_flag;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output y_out,
        output sat_flag,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  y_out,
        input  sat_flag,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fir_acc_out.sv
// -----------------------------------------------------------------------------
// fir_acc_out
//   Accumulator register and output stage of the FIR datapath. Each tap strobe
//   in ACC latches the tap adder's result into the accumulator (fed back to the
//   adder as Acc_out). After TAPS taps the final sum is saturated to 16 bits and
//   offered on the output handshake.
//   Ports:
//     clk         clock, rising edge
//     rst_n       synchronous active-low reset
//     start       begin a new sample (honoured in IDLE, or at the OUT handshake)
//     add_en      tap strobe, suma_wynik valid this cycle
//     suma_wynik  adder output, WIDTH-bit two's complement
//     Acc_out     accumulator register, fed back to the adder
//     tap_cnt     taps accumulated for the current sample
//     busy        high in ACC and OUT
//     fsm_state   current FSM state (0 IDLE, 1 ACC, 2 OUT) for observation
//     ob          output sample handshake (master side)
// -----------------------------------------------------------------------------
module fir_acc_out #(
    parameter  int WIDTH = 21,
    parameter  int TAPS  = 16,
    localparam int CW    = $clog2(TAPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             add_en,
    input  logic [WIDTH-1:0] suma_wynik,
    output logic [WIDTH-1:0] Acc_out,
    output logic [CW-1:0]    tap_cnt,
    output logic             busy,
    output logic [1:0]       fsm_state,
    fir_acc_out_if.master    ob
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CW-1:0]           LAST_TAP = CW'(TAPS - 1);
    localparam logic signed [WIDTH-1:0] SAT_MAX  = WIDTH'(32767);
    localparam logic signed [WIDTH-1:0] SAT_MIN  = WIDTH'(-32768);

    state_t state, state_nx;

    // FSM-generated datapath strobes
    logic clr_acc;    // zero accumulator and tap counter
    logic take_tap;   // latch suma_wynik, count the tap
    logic last_tap;   // this tap completes the sample: register output

    // Saturation of the incoming adder value; only used on the last tap
    logic [15:0] sat_y;
    logic        sat_c;

    // ---------------------------------------------------------------- FSM reg
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------- FSM next state/strobes
    always_comb begin
        state_nx = state;
        clr_acc  = 1'b0;
        take_tap = 1'b0;
        last_tap = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_acc  = 1'b1;
                    state_nx = ACC;
                end
            end
            ACC: begin
                // start is deliberately ignored: a sample in progress is never restarted
                if (add_en) begin
                    take_tap = 1'b1;
                    if (tap_cnt == LAST_TAP) begin
                        last_tap = 1'b1;
                        state_nx = OUT;
                    end
                end
            end
            OUT: begin
                // Handshake; a concurrent start chains straight into the next sample
                if (ob.out_ready) begin
                    clr_acc  = 1'b1;
                    state_nx = start ? ACC : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ saturation
    always_comb begin
        sat_y = suma_wynik[15:0];
        sat_c = 1'b0;
        if ($signed(suma_wynik) > SAT_MAX) begin
            sat_y = 16'h7FFF;
            sat_c = 1'b1;
        end else if ($signed(suma_wynik) < SAT_MIN) begin
            sat_y = 16'h8000;
            sat_c = 1'b1;
        end
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Acc_out     <= '0;
            tap_cnt     <= '0;
            ob.y_out    <= '0;
            ob.sat_flag <= 1'b0;
        end else begin
            if (clr_acc) begin
                Acc_out <= '0;
                tap_cnt <= '0;
            end else if (take_tap) begin
                Acc_out <= suma_wynik;
                tap_cnt <= tap_cnt + CW'(1);
            end
            if (last_tap) begin
                ob.y_out    <= sat_y;
                ob.sat_flag <= sat_c;
            end
        end
    end

    // Outputs decoded from registered state only
    assign ob.out_valid = (state == OUT);
    assign busy         = (state != IDLE);
    assign fsm_state    = state;

endmodule

// File: doc/fir_acc_out.md
# fir_acc_out

Accumulator register and output stage of the FIR datapath, directly downstream of the tap adder. Each cycle `add_en` is high it latches the adder's `suma_wynik` into the accumulator and feeds it back as `Acc_out`. After `TAPS` accumulations it saturates the WIDTH-bit sum to a 16-bit sample and presents it on a valid/ready output handshake.

## Interface
- `WIDTH`, 21: accumulator width in bits. Must be greater than 16.
- `TAPS`, 16: number of accumulations per output sample. Must be at least 1.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a new sample. Clears the accumulator and the tap counter.
- `add_en`  in  1  tap strobe: `suma_wynik` is valid this cycle.
- `suma_wynik`  in  WIDTH  adder output, two's complement.
- `Acc_out`  out  WIDTH  accumulator register, fed back to the adder.
- `tap_cnt`  out  $clog2(TAPS+1)  number of taps accumulated for the current sample.
- `busy`  out  1  high in ACC and OUT states.
- `y_out`  out  16  saturated output sample, two's complement.
- `sat_flag`  out  1  high with `out_valid` when `y_out` was clipped.
- `out_valid`  out  1  output sample available.
- `out_ready`  in  1  downstream accepts the sample.

## Operation
- States: IDLE, ACC, OUT. Reset state is IDLE.
- IDLE:
  - `start`=1: `Acc_out`<=0, `tap_cnt`<=0, go to ACC.
  - `add_en` is ignored.
- ACC, with `add_en`=1:
  - `Acc_out`<=`suma_wynik`, `tap_cnt`<=`tap_cnt`+1.
  - If `tap_cnt`==TAPS-1: also register `y_out`<=sat16(`suma_wynik`), set `sat_flag`, go to OUT.
- ACC, with `add_en`=0: hold all state. Gaps between taps are allowed.
- `start` while in ACC is ignored; a sample in progress is never restarted.
- OUT:
  - `out_valid`=1. `y_out`, `sat_flag`, `Acc_out` and `tap_cnt` are held stable until the handshake.
  - `add_en` is ignored.
  - Handshake when `out_valid` and `out_ready` are both high.
  - Handshake with `start`=0: go to IDLE; `Acc_out`<=0, `tap_cnt`<=0.
  - Handshake with `start`=1: go to ACC directly; `Acc_out`<=0, `tap_cnt`<=0. No idle bubble.
  - `start` without a handshake is ignored.
- sat16(x):
  - x > 32767 gives 32767.
  - x < −32768 gives −32768.
  - Otherwise x[15:0].
  - `sat_flag`=1 exactly when clipping occurred.
- Accumulator arithmetic is plain WIDTH-bit two's complement. Wrap-around inside the adder is not detected here; WIDTH is sized so TAPS products cannot overflow.
- `out_ready` outside OUT has no effect.

## Timing
- Reset (`rst_n`=0 at a clock edge) takes priority over every other input, in any state including mid-sample. Reset values:
  - state = IDLE;
  - `Acc_out` = 0;
  - `tap_cnt` = 0;
  - `y_out` = 0;
  - `sat_flag` = 0;
  - `out_valid` = 0;
  - `busy` = 0.
- `start` sampled at edge N: state is ACC with `Acc_out`=0 after N. The first tap may be presented in cycle N+1.
- The last tap's `add_en` sampled at edge M: `out_valid`=1 and `y_out` are valid after M. Latency is one cycle from the last tap.
- `out_valid`, `y_out`, `sat_flag` and `busy` are registered or decoded from registered state only. No combinational path from `out_ready` to any output.
- `Acc_out` changes only on a clock edge, so the adder sees a stable operand for the whole cycle.
- Minimum sample period with back-to-back `start` at the handshake and `add_en` held high: TAPS+1 cycles.

## Test plan
- Reset mid-sample: `start`, 5 taps of 100, then `rst_n`=0 for one cycle → all outputs return to reset values; a following `add_en` without `start` leaves `Acc_out`=0.
- Basic, TAPS=4: `start`, then `suma_wynik`=10,30,60,100 on consecutive cycles with `add_en`=1 and `out_ready`=1 → `out_valid` is high one cycle after the 4th tap, `y_out`=100, `sat_flag`=0, then IDLE.
- Saturation, TAPS=4:
  - last `suma_wynik`=21'h0A000 (40960) → `y_out`=32767, `sat_flag`=1.
  - last `suma_wynik`=−50000 → `y_out`=−32768, `sat_flag`=1.
- Backpressure, TAPS=4: `out_ready`=0 for 6 cycles after `out_valid` → `y_out`, `Acc_out` and `tap_cnt`=4 stay stable, and `add_en` pulses during the stall have no effect; raising `out_ready` → one-cycle handshake, then IDLE.
- Back-to-back, TAPS=4: `start`=1 in the handshake cycle, taps of 1 continuous → second sample `y_out`=4 exactly 5 cycles after the first `out_valid`; `Acc_out` is 0 at the start of the second sample.
- Gapped taps and ignored `start`, TAPS=4: `add_en` pattern 1,0,0,1,1,0,1 with values 5,x,x,5,5,x,5 and `start` pulsed during ACC → `y_out`=5, `tap_cnt` increments only on `add_en`, `start` is ignored.
